// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: assembles MSB-first words and holds the CPU in reset until loaded.
// Optional trailing-byte checksum check enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [5:0]  word_count,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t      state;
    state_t      stateNext;
    logic [5:0]  count;
    logic [4:0]  wordIdx;
    logic [1:0]  byteIdx;
    logic [23:0] wordBuf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    logic        accept;
    logic        startOk;
    logic        lastWord;
    logic        idleOrDone;

    logic        sReadyNext;
    logic        wrEnNext;
    logic [4:0]  wrAddrNext;
    logic [31:0] wrDataNext;
    logic        cpuRstNext;
    logic        busyNext;
    logic        doneNext;
    logic        errNext;

    assign accept     = s_valid & s_ready;
    assign startOk    = start & (word_count != 6'd0);
    assign lastWord   = (({1'b0, wordIdx}) + 6'd1) == count;
    assign idleOrDone = (state == IDLE) || (state == DONE);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= 5'd0;
            wr_data     <= 32'd0;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= stateNext;
            s_ready     <= sReadyNext;
            wr_en       <= wrEnNext;
            wr_addr     <= wrAddrNext;
            wr_data     <= wrDataNext;
            cpu_reset_n <= cpuRstNext;
            busy        <= busyNext;
            done        <= doneNext;
            err         <= errNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (startOk) stateNext = RECV;
            RECV:    if (accept && byteIdx == 2'd3) stateNext = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            WRITE:   stateNext = lastWord ? CHECK : RECV;
            CHECK:   if (accept) stateNext = DONE;
`else
            WRITE:   stateNext = lastWord ? DONE : RECV;
`endif
            DONE:    if (startOk) stateNext = RECV;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        sReadyNext = (stateNext == RECV) || (stateNext == CHECK);
        busyNext   = stateNext inside {RECV, WRITE, CHECK};
`else
        sReadyNext = stateNext == RECV;
        busyNext   = stateNext inside {RECV, WRITE};
`endif
        doneNext   = stateNext == DONE;
        wrEnNext   = stateNext == WRITE;
        wrAddrNext = wrEnNext ? wordIdx : wr_addr;
        // WRITE is only entered on the cycle byte3 is on s_data
        wrDataNext = wrEnNext ? {wordBuf, s_data} : wr_data;
        errNext    = err;
        if (idleOrDone && startOk)
            errNext = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state == CHECK && accept)
            errNext = (sum + s_data) != 8'd0;
`else
        errNext    = 1'b0;
`endif
        cpuRstNext = doneNext & ~errNext;
    end

    // Word assembly, indices and checksum
    always_ff @(posedge clk) begin
        if (!Reset) begin
            count   <= 6'd0;
            wordIdx <= 5'd0;
            byteIdx <= 2'd0;
            wordBuf <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum     <= 8'd0;
`endif
        end else begin
            if (idleOrDone && startOk) begin
                count   <= (word_count > 6'd32) ? 6'd32 : word_count;
                wordIdx <= 5'd0;
                byteIdx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum     <= 8'd0;
`endif
            end
            if (state == RECV && accept) begin
                byteIdx <= byteIdx + 2'd1;
                case (byteIdx)
                    2'd0:    wordBuf[23:16] <= s_data;
                    2'd1:    wordBuf[15:8]  <= s_data;
                    2'd2:    wordBuf[7:0]   <= s_data;
                    default: ;
                endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum <= sum + s_data;
`endif
            end
            // The index saturates on the last word so count=32 never wraps
            if (state == WRITE && !lastWord)
                wordIdx <= wordIdx + 5'd1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: write scoreboard plus session table and hand-written corner cases.
// Also exercises the checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [5:0]  word_count;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wrCount = 0;
    logic [7:0] tbSum;
    logic [36:0] wrQ[$];

    typedef struct {
        logic [5:0] wc;
        int         gap;
        int         expWrites;
    } vec_t;

    vec_t vecs[6];

    imem_loader dut (
        .clk(clk),
        .Reset(Reset),
        .start(start),
        .word_count(word_count),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cpu_reset_n(cpu_reset_n),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wrCount++;
            if (wrQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
            end else begin
                logic [36:0] e;
                e = wrQ.pop_front();
                check("wr_addr", {59'd0, wr_addr}, {59'd0, e[36:32]});
                check("wr_data", {32'd0, wr_data}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got s_ready 0 expected 1");
        end
        tbSum = tbSum + b;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic sendWord(input logic [4:0] addr, input logic [31:0] w, input int gap);
        wrQ.push_back({addr, w});
        for (int b = 0; b < 4; b++) begin
            logic [7:0] by;
            by = w[31 - 8*b -: 8];
            sendByte(by, gap);
        end
    endtask

    task automatic doStart(input logic [5:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start      = 1'b0;
        word_count = 6'($urandom);
        tbSum      = 8'd0;
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_done", {63'd0, done}, 64'd0);
        check("start_cpurst", {63'd0, cpu_reset_n}, 64'd0);
        check("start_ready", {63'd0, s_ready}, 64'd1);
    endtask

    task automatic endSession();
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'(8'd0 - tbSum), 0);
`endif
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done 0 expected 1");
        end
    endtask

    task automatic checkResetState(input string name);
        check(name, {45'd0, s_ready, wr_en, wr_addr, wr_data, cpu_reset_n, busy, done, err}, 64'd0);
    endtask

    initial begin
        int base;
        vecs[0] = '{6'd3, 0, 3};
        vecs[1] = '{6'd1, 2, 1};
        vecs[2] = '{6'd40, 0, 32};
        vecs[3] = '{6'd32, 1, 32};
        vecs[4] = '{6'd5, 3, 5};
        vecs[5] = '{6'd63, 0, 32};

        Reset      = 1'b0;
        start      = 1'b0;
        word_count = 6'd0;
        s_valid    = 1'b0;
        s_data     = 8'd0;
        tbSum      = 8'd0;
        repeat (3) @(negedge clk);
        checkResetState("reset_state");
        Reset = 1'b1;
        @(negedge clk);

        // Zero-length start is ignored
        start      = 1'b1;
        word_count = 6'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("zero_wc_busy", {63'd0, busy}, 64'd0);
        check("zero_wc_done", {63'd0, done}, 64'd0);
        check("zero_wc_ready", {63'd0, s_ready}, 64'd0);

        // Two words back-to-back
        base = wrCount;
        doStart(6'd2);
        sendWord(5'd0, 32'hA1290000, 0);
        sendWord(5'd1, 32'hA14A0001, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        endSession();
        waitDone();
`else
        check("lat_wr_en", {63'd0, wr_en}, 64'd1);
        check("lat_not_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        check("lat_done", {63'd0, done}, 64'd1);
`endif
        check("b2b_writes", 64'(wrCount - base), 64'd2);
        check("b2b_cpurst", {63'd0, cpu_reset_n}, 64'd1);
        check("b2b_busy", {63'd0, busy}, 64'd0);

        // Same stream with 3-cycle gaps, restarted from DONE
        base = wrCount;
        doStart(6'd2);
        sendWord(5'd0, 32'hA1290000, 3);
        sendWord(5'd1, 32'hA14A0001, 3);
        endSession();
        waitDone();
        check("gap_writes", 64'(wrCount - base), 64'd2);
        check("gap_cpurst", {63'd0, cpu_reset_n}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            base = wrCount;
            doStart(vecs[i].wc);
            for (int w = 0; w < vecs[i].expWrites; w++)
                sendWord(5'(w), $urandom, vecs[i].gap);
            endSession();
            waitDone();
            check("vec_writes", 64'(wrCount - base), 64'(vecs[i].expWrites));
            check("vec_done", {63'd0, done}, 64'd1);
            check("vec_cpurst", {63'd0, cpu_reset_n}, 64'd1);
            check("vec_err", {63'd0, err}, 64'd0);
            s_valid = 1'b1;
            repeat (2) @(negedge clk);
            check("vec_extra_ready", {63'd0, s_ready}, 64'd0);
            s_valid = 1'b0;
        end

        // Reset in the middle of a word, then a clean one-word load
        doStart(6'd1);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        Reset = 1'b0;
        @(negedge clk);
        checkResetState("midreset_state");
        Reset = 1'b1;
        @(negedge clk);
        base = wrCount;
        doStart(6'd1);
        sendWord(5'd0, 32'h012A8820, 0);
        endSession();
        waitDone();
        check("midreset_writes", 64'(wrCount - base), 64'd1);
        check("midreset_cpurst", {63'd0, cpu_reset_n}, 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        doStart(6'd1);
        sendWord(5'd0, 32'h00000005, 0);
        sendByte(8'hFB, 0);
        waitDone();
        check("csum_ok_err", {63'd0, err}, 64'd0);
        check("csum_ok_cpurst", {63'd0, cpu_reset_n}, 64'd1);
        doStart(6'd1);
        sendWord(5'd0, 32'h00000005, 0);
        sendByte(8'hFC, 0);
        waitDone();
        check("csum_bad_err", {63'd0, err}, 64'd1);
        check("csum_bad_done", {63'd0, done}, 64'd1);
        check("csum_bad_cpurst", {63'd0, cpu_reset_n}, 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(wrQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
